// File: rtl/nco_acq_pkg.sv
// Shared types and default thresholds for the NCO carrier-acquisition controller.
// Also covers the optional NCO_ACQ_RESWEEP_EN feature: UNLOCK_CNT_DEFAULT is used only when it is enabled.
package nco_acq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        TRACK = 2'd2
    } state_t;

    localparam int LOCK_CNT_DEFAULT   = 4;
    localparam int UNLOCK_CNT_DEFAULT = 16;

endpackage

// File: rtl/nco_sweep_gen.sv
// Zig-zag sweep point generator: center, +1, -1, +2, -2 ... +N, -N, each held for dwell cycles.
// The offset is accumulated one step at a time, so no multiplier is needed.
module nco_sweep_gen #(
    parameter int PHASE_WIDTH = 32,
    parameter int NSTEP_W     = 8,
    parameter int DWELL_W     = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          capture,
    input  logic                          load,
    input  logic                          advance,
    input  logic                          run,
    input  logic signed [PHASE_WIDTH-1:0] f_center,
    input  logic        [PHASE_WIDTH-1:0] f_step,
    input  logic        [NSTEP_W-1:0]     n_steps,
    input  logic        [DWELL_W-1:0]     dwell,
    output logic signed [PHASE_WIDTH-1:0] center,
    output logic signed [PHASE_WIDTH-1:0] next_word,
    output logic                          dwell_done,
    output logic                          last_point
);

    logic [PHASE_WIDTH-1:0] step;
    logic [NSTEP_W-1:0]     n_max;
    logic [DWELL_W-1:0]     dwell_len;
    logic [PHASE_WIDTH-1:0] offset, offset_nxt;
    logic [NSTEP_W-1:0]     mag, mag_nxt;
    logic                   neg, neg_nxt;
    logic [DWELL_W-1:0]     dwell_cnt;

    assign last_point = neg && (mag == n_max);
    assign dwell_done = (dwell_cnt == dwell_len - DWELL_W'(1));

    // Next point: after a minus point (or the center) the magnitude grows and the sign flips to plus.
    always_comb begin
        offset_nxt = offset;
        mag_nxt    = mag;
        neg_nxt    = neg;
        next_word  = center;
        if (neg) begin
            offset_nxt = offset + step;
            mag_nxt    = mag + NSTEP_W'(1);
            neg_nxt    = 1'b0;
            next_word  = center + offset_nxt;
        end else begin
            neg_nxt    = 1'b1;
            next_word  = center - offset;
        end
    end

    // Captured configuration, point state and dwell counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            center    <= '0;
            step      <= '0;
            n_max     <= '0;
            dwell_len <= '0;
            offset    <= '0;
            mag       <= '0;
            neg       <= 1'b0;
            dwell_cnt <= '0;
        end else begin
            if (capture) begin
                center    <= f_center;
                step      <= f_step;
                n_max     <= n_steps;
                dwell_len <= (dwell == '0) ? DWELL_W'(1) : dwell;
            end
            // The center point is tagged as a minus point so the first advance goes to +1 step.
            if (load) begin
                offset    <= '0;
                mag       <= '0;
                neg       <= 1'b1;
                dwell_cnt <= '0;
            end else if (advance) begin
                offset    <= offset_nxt;
                mag       <= mag_nxt;
                neg       <= neg_nxt;
                dwell_cnt <= '0;
            end else if (run) begin
                dwell_cnt <= dwell_cnt + DWELL_W'(1);
            end
        end
    end

endmodule

// File: rtl/nco_acq_ctrl.sv
// Carrier-acquisition controller: sweeps the NCO word, qualifies lock, then tracks with the loop correction.
// Optional feature macro NCO_ACQ_RESWEEP_EN: re-sweep after UNLOCK_CNT consecutive lock-low cycles in TRACK.
module nco_acq_ctrl
    import nco_acq_pkg::*;
#(
    parameter int PHASE_WIDTH = 32,
    parameter int NSTEP_W     = 8,
    parameter int DWELL_W     = 16,
`ifdef NCO_ACQ_RESWEEP_EN
    parameter int UNLOCK_CNT  = UNLOCK_CNT_DEFAULT,
`endif
    parameter int LOCK_CNT    = LOCK_CNT_DEFAULT
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start_i,
    input  logic                          abort_i,
    input  logic signed [PHASE_WIDTH-1:0] f_center_i,
    input  logic        [PHASE_WIDTH-1:0] f_step_i,
    input  logic        [NSTEP_W-1:0]     n_steps_i,
    input  logic        [DWELL_W-1:0]     dwell_i,
    input  logic                          lock_i,
    input  logic signed [PHASE_WIDTH-1:0] loop_corr_i,
    input  logic                          loop_vld_i,
    output logic signed [PHASE_WIDTH-1:0] freq_word_o,
    output logic                          loop_clr_o,
    output logic                          sweep_fail_o,
    output logic [1:0]                    state_o,
    output logic                          busy_o,
    output logic                          locked_o
);

    localparam int LW = $clog2(LOCK_CNT + 1);

    state_t                        state, state_nxt;
    logic signed [PHASE_WIDTH-1:0] word, word_nxt;
    logic signed [PHASE_WIDTH-1:0] f_lock, f_lock_nxt;
    logic [LW-1:0]                 lock_cnt, lock_cnt_nxt;
    logic                          clr, clr_nxt;
    logic                          fail, fail_nxt;
    logic                          busy, busy_nxt;
    logic                          locked, locked_nxt;
    logic                          gen_capture, gen_load, gen_advance, gen_run;
    logic signed [PHASE_WIDTH-1:0] center, next_word;
    logic                          dwell_done, last_point;
`ifdef NCO_ACQ_RESWEEP_EN
    localparam int UW = $clog2(UNLOCK_CNT + 1);
    logic [UW-1:0]                 unlock_cnt, unlock_cnt_nxt;
`endif

    assign gen_run = (state == SWEEP);

    nco_sweep_gen #(
        .PHASE_WIDTH (PHASE_WIDTH),
        .NSTEP_W     (NSTEP_W),
        .DWELL_W     (DWELL_W)
    ) u_sweep (
        .clk        (clk),
        .rst        (rst),
        .capture    (gen_capture),
        .load       (gen_load),
        .advance    (gen_advance),
        .run        (gen_run),
        .f_center   (f_center_i),
        .f_step     (f_step_i),
        .n_steps    (n_steps_i),
        .dwell      (dwell_i),
        .center     (center),
        .next_word  (next_word),
        .dwell_done (dwell_done),
        .last_point (last_point)
    );

    // Next-state and datapath decisions; abort outranks start, lock outranks dwell expiry.
    always_comb begin
        state_nxt    = state;
        word_nxt     = word;
        f_lock_nxt   = f_lock;
        lock_cnt_nxt = lock_cnt;
        clr_nxt      = 1'b0;
        fail_nxt     = 1'b0;
        gen_capture  = 1'b0;
        gen_load     = 1'b0;
        gen_advance  = 1'b0;
`ifdef NCO_ACQ_RESWEEP_EN
        unlock_cnt_nxt = unlock_cnt;
`endif
        if (abort_i) begin
            state_nxt    = IDLE;
            lock_cnt_nxt = '0;
        end else if (start_i) begin
            state_nxt    = SWEEP;
            word_nxt     = f_center_i;
            gen_capture  = 1'b1;
            gen_load     = 1'b1;
            lock_cnt_nxt = '0;
        end else begin
            case (state)
                SWEEP: begin
                    if (lock_i && (lock_cnt == LW'(LOCK_CNT - 1))) begin
                        state_nxt    = TRACK;
                        f_lock_nxt   = word;
                        clr_nxt      = 1'b1;
                        lock_cnt_nxt = '0;
`ifdef NCO_ACQ_RESWEEP_EN
                        unlock_cnt_nxt = '0;
`endif
                    end else if (dwell_done) begin
                        lock_cnt_nxt = '0;
                        if (last_point) begin
                            state_nxt = IDLE;
                            fail_nxt  = 1'b1;
                            word_nxt  = center;
                        end else begin
                            gen_advance = 1'b1;
                            word_nxt    = next_word;
                        end
                    end else if (lock_i) begin
                        lock_cnt_nxt = lock_cnt + LW'(1);
                    end else begin
                        lock_cnt_nxt = '0;
                    end
                end
                TRACK: begin
                    if (loop_vld_i) begin
                        word_nxt = f_lock + loop_corr_i;
                    end else begin
                        word_nxt = word;
                    end
`ifdef NCO_ACQ_RESWEEP_EN
                    // Sustained loss of lock restarts the sweep with the captured configuration.
                    if (lock_i) begin
                        unlock_cnt_nxt = '0;
                    end else if (unlock_cnt == UW'(UNLOCK_CNT - 1)) begin
                        state_nxt      = SWEEP;
                        word_nxt       = center;
                        gen_load       = 1'b1;
                        lock_cnt_nxt   = '0;
                        unlock_cnt_nxt = '0;
                    end else begin
                        unlock_cnt_nxt = unlock_cnt + UW'(1);
                    end
`endif
                end
                IDLE: begin
                    state_nxt = IDLE;
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
        busy_nxt   = (state_nxt != IDLE);
        locked_nxt = (state_nxt == TRACK);
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            word     <= '0;
            f_lock   <= '0;
            lock_cnt <= '0;
            clr      <= 1'b0;
            fail     <= 1'b0;
            busy     <= 1'b0;
            locked   <= 1'b0;
`ifdef NCO_ACQ_RESWEEP_EN
            unlock_cnt <= '0;
`endif
        end else begin
            state    <= state_nxt;
            word     <= word_nxt;
            f_lock   <= f_lock_nxt;
            lock_cnt <= lock_cnt_nxt;
            clr      <= clr_nxt;
            fail     <= fail_nxt;
            busy     <= busy_nxt;
            locked   <= locked_nxt;
`ifdef NCO_ACQ_RESWEEP_EN
            unlock_cnt <= unlock_cnt_nxt;
`endif
        end
    end

    assign freq_word_o  = word;
    assign loop_clr_o   = clr;
    assign sweep_fail_o = fail;
    assign state_o      = state;
    assign busy_o       = busy;
    assign locked_o     = locked;

endmodule

// File: doc/nco_acq_ctrl.md
# nco_acq_ctrl

Carrier-acquisition controller for the receive NCO. It drives the NCO frequency word through a zig-zag frequency sweep around a programmed center and dwells at each point while it waits for a qualified lock indication. Once lock is qualified it hands control to the carrier loop filter by adding the loop correction to the captured lock frequency. It sits between the rx configuration registers, the lock detector, the loop filter and the NCO `freq_word_i` input.

## Interface
- PHASE_WIDTH, 32: frequency-word width; matches the NCO accumulator.
- NSTEP_W, 8: width of `n_steps_i`.
- DWELL_W, 16: width of `dwell_i` and the dwell counter.
- LOCK_CNT, 4: consecutive `lock_i` cycles required to declare lock.
- UNLOCK_CNT, 16: consecutive `!lock_i` cycles that declare loss of lock (macro feature only).
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- start_i  in  1  pulse; captures the config inputs and starts a sweep.
- abort_i  in  1  pulse; returns to IDLE.
- f_center_i  in  PHASE_WIDTH  signed sweep center word.
- f_step_i  in  PHASE_WIDTH  unsigned sweep step.
- n_steps_i  in  NSTEP_W  sweep half-span N; gives 2N+1 points.
- dwell_i  in  DWELL_W  cycles per point; 0 is treated as 1.
- lock_i  in  1  raw lock indication from the lock detector.
- loop_corr_i  in  PHASE_WIDTH  signed total loop-filter correction.
- loop_vld_i  in  1  `loop_corr_i` is valid.
- freq_word_o  out  PHASE_WIDTH  signed word to the NCO; registered.
- loop_clr_o  out  1  one-cycle pulse that clears the loop-filter integrator.
- sweep_fail_o  out  1  one-cycle pulse when the sweep is exhausted.
- state_o  out  2  0 = IDLE, 1 = SWEEP, 2 = TRACK.
- busy_o  out  1  state != IDLE.
- locked_o  out  1  state == TRACK.

## Operation
- **Reset values:** state IDLE, `freq_word_o` = 0, all pulses 0, all counters 0.
- **Capture:** `start_i` captures `f_center_i`, `f_step_i`, `n_steps_i` and `dwell_i`. Later changes to these inputs are ignored until the next start.
- **Priority:** `rst` > `abort_i` > `start_i`.
  - `start_i` in any state restarts the sweep from point 0.
  - `abort_i` goes to IDLE and holds `freq_word_o` at its last value.
- **Sweep order:** center, +1 step, −1 step, +2, −2 … +N, −N.
  - The offset is built incrementally: an offset register adds `f_step` each time the magnitude increments, so no multiplier is used.
  - Output word = center ± offset.
  - All adds and subtracts are modulo 2^PHASE_WIDTH (natural wrap, no saturation).
- **SWEEP dwell:** the dwell counter holds each point for exactly `dwell` cycles.
  - The lock counter counts consecutive `lock_i` cycles and clears on any low cycle and on every point change.
  - When the lock counter reaches LOCK_CNT, the next cycle enters TRACK, `f_lock` is captured as the current word, and `loop_clr_o` pulses.
  - Lock qualification takes priority over dwell expiry in the same cycle.
- **Sweep exhaustion:** when the dwell of the last point expires without lock, the next cycle enters IDLE, `sweep_fail_o` pulses, and `freq_word_o` = center.
- **TRACK:** when `loop_vld_i` = 1, `freq_word_o` is updated to `f_lock + loop_corr_i` (modular). Otherwise it holds.
- **N = 0:** a single-point sweep at center.

## Timing
- `start_i` at cycle t: state SWEEP and `freq_word_o` = center at t+1.
- Each point is valid for exactly `dwell` cycles; there are no gap cycles between points.
- Total sweep time: (2N+1)·dwell cycles. The fail pulse is asserted in the first cycle after the last dwell.
- Lock: with `lock_i` high on cycles t..t+LOCK_CNT−1, state is TRACK and `loop_clr_o` = 1 at t+LOCK_CNT.
- `loop_vld_i` at cycle t: the new `freq_word_o` appears at t+1.
- `abort_i` or `start_i` takes effect on the next edge, including mid-dwell.

## Configuration
- Macro: `NCO_ACQ_RESWEEP_EN`.
- **Defined:** in TRACK, UNLOCK_CNT consecutive `!lock_i` cycles cause a re-entry to SWEEP at point 0 with `freq_word_o` = center on the next cycle. The lock counter restarts.
- **Undefined:** TRACK persists until `abort_i`, `start_i` or `rst`, and `lock_i` is ignored in TRACK.

## Structure
- **Package `nco_acq_pkg`:** the state enum (`IDLE`, `SWEEP`, `TRACK`, 2-bit) and the default LOCK_CNT and UNLOCK_CNT constants.
- **Sub-module `nco_sweep_gen`:** the zig-zag point index, offset accumulator, sign toggle, dwell counter and `last_point` flag. It is driven by `load` and `advance` from the top-level FSM.

## Test plan
- **Sweep sequence and fail pulse:** center 0x0100_0000, step 0x0010_0000, N = 2, dwell 8, `lock_i` = 0.
  - Words each held 8 cycles: 0x0100_0000, 0x0110_0000, 0x00F0_0000, 0x0120_0000, 0x00E0_0000.
  - `sweep_fail_o` pulses 41 cycles after `start_i`; IDLE with `freq_word_o` = 0x0100_0000.
- **Wrap-around:** center 0x7FFF_FFF0, step 0x20, N = 1 → second point 0x8000_0010, third point 0x7FFF_FFD0.
- **Lock and track:** same config as the first test; `lock_i` high for 4 cycles during the third point.
  - TRACK with `loop_clr_o` pulse, `f_lock` = 0x00F0_0000.
  - `loop_corr_i` = −0x100 with `loop_vld_i` → `freq_word_o` = 0x00EF_FF00 the next cycle.
- **Lock counter reset on point change:** `lock_i` high for 3 cycles spanning a point change → no lock.
- **Mid-operation control:**
  - `abort_i` at dwell cycle 3 → IDLE next cycle with word held.
  - `start_i` and `abort_i` in the same cycle → IDLE.
  - `rst` mid-sweep → all outputs 0.
- **`NCO_ACQ_RESWEEP_EN` on:** in TRACK, `lock_i` low for 16 cycles → SWEEP with `freq_word_o` = center. With the macro off, state stays TRACK.
